// File: rtl/seg_scan_pkg.sv
//----------------------------------------------------------------------------
// Module      : seg_scan_pkg
// Description : Glyph constants and sizing helper for the seg_scan_hex driver.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package seg_scan_pkg;

    // Segment order is a..g with seg[0]=a; active-low, so 0 = lit.
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] GLYPH_0   = 7'b0000001;
    localparam logic [0:6] GLYPH_1   = 7'b1001111;
    localparam logic [0:6] GLYPH_2   = 7'b0010010;
    localparam logic [0:6] GLYPH_3   = 7'b0000110;
    localparam logic [0:6] GLYPH_4   = 7'b1001100;
    localparam logic [0:6] GLYPH_5   = 7'b0100100;
    localparam logic [0:6] GLYPH_6   = 7'b0100000;
    localparam logic [0:6] GLYPH_7   = 7'b0001111;
    localparam logic [0:6] GLYPH_8   = 7'b0000000;
    localparam logic [0:6] GLYPH_9   = 7'b0000100;
    localparam logic [0:6] GLYPH_A   = 7'b0001000;
    localparam logic [0:6] GLYPH_B   = 7'b1100000;
    localparam logic [0:6] GLYPH_C   = 7'b0110001;
    localparam logic [0:6] GLYPH_D   = 7'b1000010;
    localparam logic [0:6] GLYPH_E   = 7'b0110000;
    localparam logic [0:6] GLYPH_F   = 7'b0111000;

    // Counter width that stays at least one bit for degenerate counts.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_glyph.sv
//----------------------------------------------------------------------------
// Module      : hex_glyph
// Description : Combinational hex nibble to active-low 7-segment glyph decoder.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module hex_glyph
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [0:6] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = GLYPH_0;
            4'h1: o_seg = GLYPH_1;
            4'h2: o_seg = GLYPH_2;
            4'h3: o_seg = GLYPH_3;
            4'h4: o_seg = GLYPH_4;
            4'h5: o_seg = GLYPH_5;
            4'h6: o_seg = GLYPH_6;
            4'h7: o_seg = GLYPH_7;
            4'h8: o_seg = GLYPH_8;
            4'h9: o_seg = GLYPH_9;
            4'hA: o_seg = GLYPH_A;
            4'hB: o_seg = GLYPH_B;
            4'hC: o_seg = GLYPH_C;
            4'hD: o_seg = GLYPH_D;
            4'hE: o_seg = GLYPH_E;
            4'hF: o_seg = GLYPH_F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_hex.sv
//----------------------------------------------------------------------------
// Module      : seg_scan_hex
// Description : Scanned common-anode hex display driver with dead time and
//               leading-zero blanking. Optional blink via SEG_SCAN_BLINK_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module seg_scan_hex
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 2
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_IW = idx_width(NUM_DIGITS);
    localparam int c_PW = idx_width(SCAN_DIV);

    logic [c_PW-1:0]         r_presc;
    logic [c_IW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [0:6]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_dead;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_lz_sel;
    logic                    w_mask_sel;
    logic                    w_blank;
    logic                    w_zero_above;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [0:6]              w_glyph;

    assign w_slot_end = (r_presc == c_PW'(SCAN_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == c_IW'(NUM_DIGITS - 1));
    assign w_dead     = (int'(r_presc) < DEAD_CYCLES);

    // Digit i is a leading zero when it and every digit to its left are 0.
    always_comb begin
        w_zero_above = 1'b1;
        w_lz         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_shadow[4*i +: 4] == 4'h0);
            w_lz[i]      = w_zero_above && (i != 0);
        end
    end

    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_lz_sel   = 1'b0;
        w_mask_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nib    = r_shadow[4*i +: 4];
                w_dp_sel = r_shadow_dp[i];
                w_lz_sel = w_lz[i];
`ifdef SEG_SCAN_BLINK_EN
                w_mask_sel = blink_mask[i];
`endif
            end
        end
    end

    hex_glyph u_hex_glyph (
        .i_nibble (w_nib),
        .o_seg    (w_glyph)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int c_BW = idx_width(BLINK_FRAMES);

    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_frame_done) begin
            if (r_blink_cnt == c_BW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank = (blank_lz && w_lz_sel) || (r_blink_off && w_mask_sel);
`else
    assign w_blank = (blank_lz && w_lz_sel) || (1'b0 && w_mask_sel);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_slot_end ? '0 : r_presc + 1'b1;
            r_frame_done <= w_wrap;
            if (w_wrap) begin
                r_idx <= '0;
            end else if (w_slot_end) begin
                r_idx <= r_idx + 1'b1;
            end
            if (load) begin
                r_shadow    <= value;
                r_shadow_dp <= dp_in;
            end
            if (w_dead) begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_blank ? SEG_BLANK : w_glyph;
                r_dp  <= w_blank ? 1'b1 : ~w_dp_sel;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_hex.sv
//----------------------------------------------------------------------------
// Module      : tb_seg_scan_hex
// Description : Self-checking bench for seg_scan_hex against a cycle-count model.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_hex;

    localparam int ND   = 4;
    localparam int SD   = 8;
    localparam int DC   = 2;
    localparam int FRM  = ND * SD;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank_lz;
    logic [0:6]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles since reset release plus shadow contents.
    int          m_t  = 0;
    logic [15:0] m_sh = '0;
    logic [3:0]  m_dp = '0;
    logic [0:6]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    logic [0:6] GL [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg_scan_hex #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance one clock: derive expected outputs from the pre-edge model
    // state, update the model, then leave 1 time unit for outputs to settle.
    task automatic tick();
        int p, d;
        logic [15:0] upper;
        @(posedge clk);
        if (reset) begin
            e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
            m_t = 0; m_sh = '0; m_dp = '0;
        end else begin
            p     = m_t % SD;
            d     = (m_t / SD) % ND;
            e_fd  = ((m_t % FRM) == FRM - 1);
            upper = m_sh >> (4 * d);
            if (p < DC) begin
                e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'hF;
            end else begin
                e_an = 4'hF & ~(4'b0001 << d);
                if (blank_lz && d > 0 && upper == 16'h0) begin
                    e_seg = 7'b1111111; e_dp = 1'b1;
                end else begin
                    e_seg = GL[upper[3:0]];
                    e_dp  = ~m_dp[d];
                end
            end
            m_t = m_t + 1;
            if (load) begin
                m_sh = value; m_dp = dp_in;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (an !== 4'hF || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
                         an, seg, dp, frame_done);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if (i < 3 && an !== 4'hF) begin
                n_err++;
                $display("FAIL dead_after_reset: cycle %0d an=%b want 1111", i, an);
            end
            if (i == 3 && (an !== 4'b1110 || seg !== 7'b0000001)) begin
                n_err++;
                $display("FAIL first_lit: an=%b seg=%b want an=1110 seg=0000001", an, seg);
            end
        end
    endtask

    task automatic test_digits();
        int fd_cnt;
        logic [0:6] seen_seg [4];
        logic       seen_dp  [4];
        value = 16'hBD0C; dp_in = 4'b0100; blank_lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_t % FRM != 0) tick();
        fd_cnt = 0;
        for (int c = 0; c < FRM; c++) begin
            tick();
            if (frame_done === 1'b1) fd_cnt++;
            for (int k = 0; k < ND; k++)
                if (an === (4'hF & ~(4'b0001 << k))) begin
                    seen_seg[k] = seg; seen_dp[k] = dp;
                end
            n_vec++;
            if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
                n_err++;
                $display("FAIL digits_model: t=%0d seg=%b dp=%b an=%b fd=%b want %b %b %b %b",
                         m_t, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
            end
        end
        n_vec++;
        if (fd_cnt != 1) begin
            n_err++;
            $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
        end
        n_vec++;
        if (seen_seg[0] !== 7'b0110001 || seen_seg[1] !== 7'b0000001 || seen_seg[2] !== 7'b1000010 ||
            seen_seg[3] !== 7'b1100000 || seen_dp[1] !== 1'b1 || seen_dp[2] !== 1'b0) begin
            n_err++;
            $display("FAIL digits_BD0C: seg0=%b seg1=%b seg2=%b seg3=%b dp1=%b dp2=%b",
                     seen_seg[0], seen_seg[1], seen_seg[2], seen_seg[3], seen_dp[1], seen_dp[2]);
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            value = vals[v]; dp_in = '0; blank_lz = 1'b1; load = 1'b1;
            tick();
            load = 1'b0;
            for (int c = 0; c < FRM; c++) begin
                tick();
                n_vec++;
                if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
                    n_err++;
                    $display("FAIL leading_zero: val=%h an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             vals[v], an, seg, dp, e_an, e_seg, e_dp);
                end
                if (v == 0 && an === 4'b1101 && seg !== 7'b1001100) begin
                    n_err++;
                    $display("FAIL lz_digit1: seg=%b want 1001100", seg);
                end
                if (v == 1 && an !== 4'b1110 && an !== 4'hF && seg !== 7'b1111111) begin
                    n_err++;
                    $display("FAIL lz_zero_blank: an=%b seg=%b want 1111111", an, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 3) == 0);
            blank_lz = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
            tick();
            n_vec++;
            if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
                n_err++;
                $display("FAIL random: t=%0d seg=%b dp=%b an=%b fd=%b want %b %b %b %b",
                         m_t, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
            end
            if ($countones(~an) > 1) begin
                n_err++;
                $display("FAIL one_hot_anode: an=%b has more than one low bit", an);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        blank_lz = 1'b0;
        while (m_t % FRM != 2 * SD + 5 && guard < 2 * FRM) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 2 * FRM) begin
            n_err++;
            $display("FAIL reset_mid_align: could not reach digit2 prescaler5, t=%0d", m_t);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (an !== 4'hF || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_off: an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        end
        reset = 1'b0;
        for (int c = 1; c <= SD + 3; c++) begin
            tick();
            n_vec++;
            if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
                n_err++;
                $display("FAIL reset_mid_resume: c=%0d seg=%b an=%b want %b %b", c, seg, an, e_seg, e_an);
            end
            if (c >= 3 && c <= SD && (an !== 4'b1110 || seg !== 7'b0000001)) begin
                n_err++;
                $display("FAIL reset_mid_digit0: c=%0d an=%b seg=%b want 1110 0000001", c, an, seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_leading_zero();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
